gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Gshare direction predictor for the fetch-side branch prediction unit. Hashes the fetch PC with a speculative global history register (GHR) to index a table of 2-bit saturating counters and returns a taken/not-taken prediction. Pushes each prediction's table index into the downstream 7-bit circular index queue. At in-order branch resolution it pops the index back, trains the counter, and on a mispredict restores the GHR and clears the queue.

## Interface
Parameters:
- GHRWIDE, 7, GHR and index width; must equal the index queue's data width.
- PHTDEEP, 128, counter-table depth; must equal 2^GHRWIDE.
- PCLOW, 2, lowest PC bit used in the hash.

Ports:
- Clk, in, 1, single clock.
- Rest, in, 1, synchronous active-low reset.
- PredValid, in, 1, fetch requests a prediction this cycle.
- PredPc, in, 32, fetch PC.
- PredReady, out, 1, prediction accepted this cycle.
- PredTaken, out, 1, predicted direction, combinational.
- BrValid, in, 1, oldest outstanding branch resolves this cycle.
- BrTaken, in, 1, actual direction.
- BrMiss, in, 1, resolved branch was mispredicted; qualified by BrValid.
- CriqWable, out, 1, index queue write enable.
- CriqDin, out, GHRWIDE, index queue write data.
- CriqRable, out, 1, index queue read/pop enable.
- CriqPreOut, in, GHRWIDE, index at the queue tail.
- CriqFull, in, 1, queue full.
- CriqClean, out, 1, queue clear.
- StatBrCnt, out, 32, resolved-branch count. Gated by the macro below.
- StatMissCnt, out, 32, mispredict count. Gated by the macro below.

## Operation
- **Index:** Index = PredPc[PCLOW+GHRWIDE-1:PCLOW] ^ SpecGhr.
- **Prediction:** PredTaken = Pht[Index][1].
- **Accept condition:** PredReady = (State==IDLE) && !CriqFull && !(BrValid && BrMiss).
- **On accept** (PredValid && PredReady):
  - CriqWable=1 and CriqDin=Index.
  - SpecGhr <= {SpecGhr[GHRWIDE-2:0], PredTaken}.
  - OutCnt increments.
- **Resolve** (BrValid && OutCnt!=0 && State==IDLE):
  - CriqRable=1.
  - Pht[CriqPreOut] saturating-increments if BrTaken, else saturating-decrements (00 and 11 hold).
  - ComGhr <= {ComGhr[GHRWIDE-2:0], BrTaken}.
  - OutCnt decrements.
- **Ignored resolves:** BrValid with OutCnt==0, or in RECOVER, is ignored. No Rable, no update.
- **Simultaneous accept and resolve:** OutCnt is unchanged. The Pht read returns the pre-update value, even on an index collision.
- **Mispredict** (qualified resolve with BrMiss):
  - Counter trains as normal.
  - SpecGhr <= {ComGhr[GHRWIDE-2:0], BrTaken}, i.e. the same value ComGhr takes.
  - State -> RECOVER.
- **FSM:**
  - IDLE -> RECOVER on a qualified mispredict.
  - RECOVER -> IDLE unconditionally after one cycle.
  - In RECOVER: CriqClean=1, OutCnt <= 0, PredReady=0.
- **OutCnt** is 7 bits, range 0..64. It tracks queue occupancy and guards against popping an empty queue.

## Timing
- **Reset** (Rest=0 at a clock edge), including mid-RECOVER:
  - State=IDLE.
  - SpecGhr=ComGhr=0.
  - OutCnt=0.
  - All Pht entries 2'b01 (weakly not taken).
  - Stat counters 0.
  - While reset is held: CriqWable=CriqRable=CriqClean=0 and PredReady=0.
- **Prediction latency:** zero cycles. PredTaken and CriqDin are valid in the same cycle as PredPc.
- **State update latency:** GHR, Pht and OutCnt updates take effect on the next edge.
- **Mispredict sequence:** mispredict resolves at cycle N. CriqClean=1 in cycle N+1. Predictions resume in cycle N+2 using the restored SpecGhr.
- **Full boundary:** after 64 unresolved accepts CriqFull=1 and PredReady=0. No write is issued while full.

## Configuration
- Macro: BPU_STAT_EN.
- **Defined:** StatBrCnt increments on each qualified resolve. StatMissCnt increments on each qualified mispredict. Both are 32-bit and wrap.
- **Undefined:** both ports are tied to 0 and no counter registers are built.

## Structure
- **Shared define header (alongside the existing IP settings):**
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - FSM encodings IDLE and RECOVER.
  - Default GHRWIDE.
- **One sub-module, gshare_pht:**
  - PHTDEEP x 2-bit counter array.
  - One combinational read port.
  - One synchronous saturating-update port.
  - Synchronous reset to WNT.

## Test plan
- **Basic predict:** after reset, PredValid=1, PredPc=0x00000010 -> CriqDin=0x04, PredTaken=0, CriqWable=1; next cycle SpecGhr=0x00, OutCnt=1.
- **Training:** three resolves with CriqPreOut=0x04, BrTaken=1 -> Pht[0x04] goes 01 -> 10 -> 11 -> 11. With SpecGhr=0, a new predict at PC 0x10 gives PredTaken=1.
- **Full:** 64 accepts with no resolve -> CriqFull=1, PredReady=0. A 65th PredValid produces no CriqWable and OutCnt stays 64.
- **Mispredict:** ComGhr=0x05, BrValid=BrMiss=BrTaken=1 -> PredReady=0 that cycle. Next cycle CriqClean=1 for exactly one cycle, SpecGhr=0x0B, OutCnt=0. The cycle after, PredReady=1.
- **Collision:** accept and resolve at the same cycle on index 0x04 with Pht=01 and BrTaken=1 -> PredTaken=0 (old value), Pht=10 afterwards, OutCnt unchanged.
- **Empty resolve:** BrValid=1 with OutCnt=0 -> CriqRable=0, no Pht/GHR change. With BPU_STAT_EN defined, StatBrCnt is unchanged.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared types for the gshare direction predictor: counter and FSM
// encodings, default history width and the saturating counter step.
package gshare_predictor_pkg;

    localparam int GHR_W = 7;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_e;

    function automatic logic [1:0] ctr_step(
        input logic [1:0] ctr,
        input logic       up
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (up && ctr != ST) begin
            nxt = ctr + 2'd1;
        end else if (!up && ctr != SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2-bit saturating counters, one combinational
// read port, one synchronous update port, reset to weakly not taken.
module gshare_pht
    import gshare_predictor_pkg::*;
#(
    parameter int IDXW  = GHR_W,
    parameter int DEPTH = 1 << GHR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_idx,
    output logic [1:0]      rd_ctr,
    input  logic            upd_en,
    input  logic [IDXW-1:0] upd_idx,
    input  logic            upd_taken
);

    logic [1:0] pht_q [DEPTH];
    logic [1:0] pht_d [DEPTH];

    assign rd_ctr = pht_q[rd_idx];

    always_comb begin
        pht_d = pht_q;
        if (upd_en) begin
            pht_d[upd_idx] = ctr_step(pht_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= WNT;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with speculative/committed GHR and index queue.
// Optional BPU_STAT_EN builds resolved-branch and mispredict counters.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int GHRWIDE = GHR_W,
    parameter int PHTDEEP = 128,
    parameter int PCLOW   = 2
) (
    input  logic               Clk,
    input  logic               Rest,
    input  logic               PredValid,
    input  logic [31:0]        PredPc,
    output logic               PredReady,
    output logic               PredTaken,
    input  logic               BrValid,
    input  logic               BrTaken,
    input  logic               BrMiss,
    output logic               CriqWable,
    output logic [GHRWIDE-1:0] CriqDin,
    output logic               CriqRable,
    input  logic [GHRWIDE-1:0] CriqPreOut,
    input  logic               CriqFull,
    output logic               CriqClean,
    output logic [31:0]        StatBrCnt,
    output logic [31:0]        StatMissCnt
);

    state_e             state_q, state_d;
    logic [GHRWIDE-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHRWIDE-1:0] com_ghr_q, com_ghr_d;
    logic [6:0]         out_cnt_q, out_cnt_d;

    logic [GHRWIDE-1:0] idx;
    logic [GHRWIDE-1:0] com_new;
    logic [1:0]         pht_rd;
    logic               accept;
    logic               resolve;
    logic               mispred;

    gshare_pht #(
        .IDXW  (GHRWIDE),
        .DEPTH (PHTDEEP)
    ) u_pht (
        .clk       (Clk),
        .rst_n     (Rest),
        .rd_idx    (idx),
        .rd_ctr    (pht_rd),
        .upd_en    (resolve),
        .upd_idx   (CriqPreOut),
        .upd_taken (BrTaken)
    );

    always_comb begin
        idx       = PredPc[PCLOW+GHRWIDE-1:PCLOW] ^ spec_ghr_q;
        PredTaken = pht_rd[1];
        PredReady = Rest && (state_q == IDLE) && !CriqFull
                    && !(BrValid && BrMiss);
        accept    = PredValid && PredReady;
        resolve   = Rest && BrValid && (out_cnt_q != 7'd0)
                    && (state_q == IDLE);
        mispred   = resolve && BrMiss;
        com_new   = {com_ghr_q[GHRWIDE-2:0], BrTaken};
        CriqWable = accept;
        CriqDin   = idx;
        CriqRable = resolve;
        CriqClean = Rest && (state_q == RECOVER);
    end

    always_comb begin
        state_d    = state_q;
        spec_ghr_d = spec_ghr_q;
        com_ghr_d  = com_ghr_q;
        out_cnt_d  = out_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    spec_ghr_d = {spec_ghr_q[GHRWIDE-2:0], PredTaken};
                end
                if (resolve) begin
                    com_ghr_d = com_new;
                end
                // recovery restarts speculation from the committed path
                if (mispred) begin
                    spec_ghr_d = com_new;
                    state_d    = RECOVER;
                end
                if (accept && !resolve) begin
                    out_cnt_d = out_cnt_q + 7'd1;
                end else if (!accept && resolve) begin
                    out_cnt_d = out_cnt_q - 7'd1;
                end
            end
            RECOVER: begin
                state_d   = IDLE;
                out_cnt_d = 7'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            state_q    <= IDLE;
            spec_ghr_q <= '0;
            com_ghr_q  <= '0;
            out_cnt_q  <= 7'd0;
        end else begin
            state_q    <= state_d;
            spec_ghr_q <= spec_ghr_d;
            com_ghr_q  <= com_ghr_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

`ifdef BPU_STAT_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_br_d   = stat_br_q;
        stat_miss_d = stat_miss_q;
        if (resolve) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mispred) begin
            stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            stat_br_q   <= 32'd0;
            stat_miss_q <= 32'd0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign StatBrCnt   = stat_br_q;
    assign StatMissCnt = stat_miss_q;
`else
    assign StatBrCnt   = 32'd0;
    assign StatMissCnt = 32'd0;
`endif

    logic unused_ok;
    assign unused_ok = ^{PredPc[31:PCLOW+GHRWIDE], PredPc[PCLOW-1:0],
                         pht_rd[0], com_ghr_q[GHRWIDE-1]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor.
// Expected values are hand-derived from the predictor's behaviour.
module tb_gshare_predictor;

    logic        Clk;
    logic        Rest;
    logic        PredValid;
    logic [31:0] PredPc;
    logic        PredReady;
    logic        PredTaken;
    logic        BrValid;
    logic        BrTaken;
    logic        BrMiss;
    logic        CriqWable;
    logic [6:0]  CriqDin;
    logic        CriqRable;
    logic [6:0]  CriqPreOut;
    logic        CriqFull;
    logic        CriqClean;
    logic [31:0] StatBrCnt;
    logic [31:0] StatMissCnt;

    int checks = 0;
    int errors = 0;

`ifdef BPU_STAT_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    gshare_predictor dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .PredValid   (PredValid),
        .PredPc      (PredPc),
        .PredReady   (PredReady),
        .PredTaken   (PredTaken),
        .BrValid     (BrValid),
        .BrTaken     (BrTaken),
        .BrMiss      (BrMiss),
        .CriqWable   (CriqWable),
        .CriqDin     (CriqDin),
        .CriqRable   (CriqRable),
        .CriqPreOut  (CriqPreOut),
        .CriqFull    (CriqFull),
        .CriqClean   (CriqClean),
        .StatBrCnt   (StatBrCnt),
        .StatMissCnt (StatMissCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        PredValid  = 1'b0;
        PredPc     = 32'h0;
        BrValid    = 1'b0;
        BrTaken    = 1'b0;
        BrMiss     = 1'b0;
        CriqPreOut = 7'h0;
        CriqFull   = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        Rest = 1'b0;
        step();
        step();
        Rest = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end

    initial begin
        // reset holds outputs low even with requests pending
        idle_in();
        Rest      = 1'b0;
        PredValid = 1'b1;
        BrValid   = 1'b1;
        step();
        #3;
        check("rst_ready", PredReady, 0);
        check("rst_wable", CriqWable, 0);
        check("rst_rable", CriqRable, 0);
        check("rst_clean", CriqClean, 0);
        step();
        idle_in();
        Rest = 1'b1;
        #3;
        check("rst_outcnt", dut.out_cnt_q, 0);
        check("rst_pht4", dut.u_pht.pht_q[4], 1);
        check("rst_ghr", CriqDin, 0);
        check("rst_stat", StatBrCnt, 0);
        step();

        // basic predict
        PredValid = 1'b1;
        PredPc    = 32'h10;
        #3;
        check("bp_din", CriqDin, 7'h04);
        check("bp_taken", PredTaken, 0);
        check("bp_wable", CriqWable, 1);
        check("bp_ready", PredReady, 1);
        step();
        PredValid = 1'b0;
        PredPc    = 32'h0;
        #3;
        check("bp_ghr", CriqDin, 7'h00);
        check("bp_outcnt", dut.out_cnt_q, 1);
        step();

        // training: two more accepts then three taken resolves on 0x04
        PredValid = 1'b1;
        PredPc    = 32'h10;
        step();
        step();
        PredValid  = 1'b0;
        BrValid    = 1'b1;
        BrTaken    = 1'b1;
        CriqPreOut = 7'h04;
        #3;
        check("tr_rable", CriqRable, 1);
        step();
        check("tr_pht_1", dut.u_pht.pht_q[4], 2);
        step();
        check("tr_pht_2", dut.u_pht.pht_q[4], 3);
        step();
        check("tr_pht_3", dut.u_pht.pht_q[4], 3);
        check("tr_outcnt", dut.out_cnt_q, 0);
        check("tr_comghr", dut.com_ghr_q, 7'h07);
        BrValid   = 1'b0;
        PredValid = 1'b1;
        PredPc    = 32'h10;
        #3;
        check("tr_taken", PredTaken, 1);
        check("tr_din", CriqDin, 7'h04);
        step();

        // empty resolve is ignored
        do_reset();
        BrValid    = 1'b1;
        BrTaken    = 1'b1;
        CriqPreOut = 7'h04;
        #3;
        check("er_rable", CriqRable, 0);
        step();
        BrValid = 1'b0;
        #3;
        check("er_pht", dut.u_pht.pht_q[4], 1);
        check("er_comghr", dut.com_ghr_q, 0);
        check("er_specghr", CriqDin, 0);
        check("er_stat", StatBrCnt, 0);
        step();

        // collision: accept and resolve on 0x04 in one cycle
        do_reset();
        PredValid = 1'b1;
        PredPc    = 32'h10;
        step();
        BrValid    = 1'b1;
        BrTaken    = 1'b1;
        CriqPreOut = 7'h04;
        #3;
        check("co_taken", PredTaken, 0);
        check("co_wable", CriqWable, 1);
        check("co_rable", CriqRable, 1);
        step();
        idle_in();
        #3;
        check("co_pht", dut.u_pht.pht_q[4], 2);
        check("co_outcnt", dut.out_cnt_q, 1);
        step();

        // mispredict with ComGhr built up to 0x05
        do_reset();
        PredValid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        PredValid  = 1'b0;
        BrValid    = 1'b1;
        CriqPreOut = 7'h10;
        BrTaken    = 1'b1;
        step();
        BrTaken = 1'b0;
        step();
        BrTaken = 1'b1;
        step();
        check("mp_comghr", dut.com_ghr_q, 7'h05);
        check("mp_pht10", dut.u_pht.pht_q[16], 2);
        BrMiss    = 1'b1;
        PredValid = 1'b1;
        #3;
        check("mp_ready_n", PredReady, 0);
        check("mp_wable_n", CriqWable, 0);
        check("mp_rable", CriqRable, 1);
        step();
        BrValid = 1'b0;
        BrMiss  = 1'b0;
        #3;
        check("mp_clean", CriqClean, 1);
        check("mp_ready_r", PredReady, 0);
        check("mp_specghr", CriqDin, 7'h0B);
        check("mp_outcnt", dut.out_cnt_q, 0);
        check("mp_brcnt", StatBrCnt, STAT_ON * 4);
        check("mp_misscnt", StatMissCnt, STAT_ON);
        step();
        #3;
        check("mp_clean_n", CriqClean, 0);
        check("mp_ready", PredReady, 1);
        check("mp_din", CriqDin, 7'h0B);
        step();

        // full boundary after 64 unresolved accepts
        do_reset();
        PredValid = 1'b1;
        for (int i = 0; i < 64; i++) step();
        check("fu_outcnt", dut.out_cnt_q, 64);
        CriqFull = 1'b1;
        #3;
        check("fu_ready", PredReady, 0);
        check("fu_wable", CriqWable, 0);
        step();
        check("fu_hold", dut.out_cnt_q, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
